// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port arbiter in front of the shared program/data memory.
//                Port C (CPU control sequencer) and port L (loader/debug)
//                compete for one memory port. A transaction latches the
//                owner's we/addr/wdata, issues a single mem_en strobe, waits
//                MEM_LAT cycles on reads, and returns a one-cycle ack with
//                registered read data. Ties alternate round-robin.
//  Ports       : i_clk/i_rst          clock, synchronous active-high reset
//                i_c_* / o_c_ack      CPU request port
//                i_l_* / o_l_ack      loader request port
//                o_rdata              read data, valid while an ack is high
//                o_grant / o_busy     owner (bit0 = C, bit1 = L), busy flag
//                o_mem_* / i_mem_rdata  memory-side port
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1    // legal range 1..7
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_c_req,
    input  logic              i_c_we,
    input  logic [ADDR_W-1:0] i_c_addr,
    input  logic [DATA_W-1:0] i_c_wdata,
    output logic              o_c_ack,
    input  logic              i_l_req,
    input  logic              i_l_we,
    input  logic [ADDR_W-1:0] i_l_addr,
    input  logic [DATA_W-1:0] i_l_wdata,
    output logic              o_l_ack,
    output logic [DATA_W-1:0] o_rdata,
    output logic [1:0]        o_grant,
    output logic              o_busy,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    localparam logic       c_OWN_C = 1'b0;
    localparam logic       c_OWN_L = 1'b1;
    localparam logic [2:0] c_LAT   = 3'(MEM_LAT);

    state_t            state_q,     state_d;
    logic [2:0]        cnt_q,       cnt_d;
    logic              rr_last_q,   rr_last_d;
    logic              owner_q,     owner_d;
    logic              we_q,        we_d;
    logic [1:0]        grant_q,     grant_d;
    logic              busy_q,      busy_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic              c_ack_q,     c_ack_d;
    logic              l_ack_q,     l_ack_d;

    logic              w_pick_l;
    logic              w_sel_we;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_last_d   = rr_last_q;
        owner_d     = owner_q;
        we_d        = we_q;
        grant_d     = grant_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        c_ack_d     = 1'b0;
        l_ack_d     = 1'b0;
        // L wins only if C is silent, or on a tie when C was served last.
        w_pick_l    = i_l_req && (!i_c_req || (rr_last_q == c_OWN_C));
        w_sel_we    = w_pick_l ? i_l_we : i_c_we;

        case (state_q)
            S_IDLE: begin
                if (i_c_req || i_l_req) begin
                    owner_d    = w_pick_l;
                    rr_last_d  = w_pick_l;
                    we_d       = w_sel_we;
                    mem_addr_d = w_pick_l ? i_l_addr : i_c_addr;
                    // Reads leave the memory write-data register untouched.
                    if (w_sel_we) begin
                        mem_wdata_d = w_pick_l ? i_l_wdata : i_c_wdata;
                    end
                    grant_d    = w_pick_l ? 2'b10 : 2'b01;
                    // Strobe is registered so it is visible during S_ISSUE.
                    mem_en_d   = 1'b1;
                    mem_we_d   = w_sel_we;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    c_ack_d = (owner_q == c_OWN_C);
                    l_ack_d = (owner_q == c_OWN_L);
                    state_d = S_ACK;
                end else begin
                    cnt_d   = c_LAT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    rdata_d = i_mem_rdata;
                    c_ack_d = (owner_q == c_OWN_C);
                    l_ack_d = (owner_q == c_OWN_L);
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            rr_last_q   <= c_OWN_L;   // C wins the first tie after reset
            owner_q     <= c_OWN_C;
            we_q        <= 1'b0;
            grant_q     <= 2'b00;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            c_ack_q     <= 1'b0;
            l_ack_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_last_q   <= rr_last_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            c_ack_q     <= c_ack_d;
            l_ack_q     <= l_ack_d;
        end
    end

    assign o_c_ack     = c_ack_q;
    assign o_l_ack     = l_ack_q;
    assign o_rdata     = rdata_q;
    assign o_grant     = grant_q;
    assign o_busy      = busy_q;
    assign o_mem_en    = mem_en_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. Directed transactions
//                push expected memory strobes and acks into queues; a monitor
//                pops and compares whenever the DUT strobes memory or acks.
//                A second instance with MEM_LAT = 3 covers long reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT 1 : MEM_LAT = 1 ----------------
    logic       c_req = 1'b0, c_we = 1'b0, l_req = 1'b0, l_we = 1'b0;
    logic [7:0] c_addr = '0, c_wdata = '0, l_addr = '0, l_wdata = '0;
    logic       c_ack, l_ack, busy, mem_en, mem_we;
    logic [1:0] grant;
    logic [7:0] rdata, mem_addr, mem_wdata;
    logic [7:0] mem_rdata = '0;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_wdata(c_wdata), .o_c_ack(c_ack),
        .i_l_req(l_req), .i_l_we(l_we), .i_l_addr(l_addr), .i_l_wdata(l_wdata), .o_l_ack(l_ack),
        .o_rdata(rdata), .o_grant(grant), .o_busy(busy),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    // One-cycle-latency memory model.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    // ---------------- DUT 2 : MEM_LAT = 3 ----------------
    logic       c2_req = 1'b0;
    logic [7:0] c2_addr = '0;
    logic       c2_ack, l2_ack, busy2, mem_en2, mem_we2;
    logic [1:0] grant2;
    logic [7:0] rdata2, mem_addr2, mem_wdata2, mem_rdata2;
    int         k2 = 0;
    int         mem_en2_cyc = -1;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst),
        .i_c_req(c2_req), .i_c_we(1'b0), .i_c_addr(c2_addr), .i_c_wdata(8'h00), .o_c_ack(c2_ack),
        .i_l_req(1'b0), .i_l_we(1'b0), .i_l_addr(8'h00), .i_l_wdata(8'h00), .o_l_ack(l2_ack),
        .o_rdata(rdata2), .o_grant(grant2), .o_busy(busy2),
        .o_mem_en(mem_en2), .o_mem_we(mem_we2), .o_mem_addr(mem_addr2),
        .o_mem_wdata(mem_wdata2), .i_mem_rdata(mem_rdata2)
    );

    // Read data changes every cycle after the strobe; only the third value is correct.
    always @(posedge clk) begin
        if (rst)                    k2 <= 0;
        else if (mem_en2)           k2 <= 1;
        else if (k2 != 0 && k2 < 7) k2 <= k2 + 1;
    end
    assign mem_rdata2 = (k2 == 1) ? 8'h11 : (k2 == 2) ? 8'h22 : (k2 == 3) ? 8'h99 : 8'h33;
    always @(negedge clk) if (mem_en2) mem_en2_cyc = cyc;

    // ---------------- scoreboard ----------------
    typedef struct { bit is_l; bit we; logic [7:0] addr; logic [7:0] wdata; } mem_exp_t;
    typedef struct { bit is_l; bit we; logic [7:0] rdata; } ack_exp_t;
    mem_exp_t mq[$];
    ack_exp_t aq[$];
    mem_exp_t mon_me;
    ack_exp_t mon_ae;
    int       n_mem_en = 0;
    int       mem_en_cyc = -1;

    function automatic mem_exp_t mk_m(bit is_l, bit we, logic [7:0] addr, logic [7:0] wdata);
        mem_exp_t e;
        e.is_l = is_l; e.we = we; e.addr = addr; e.wdata = wdata;
        return e;
    endfunction

    function automatic ack_exp_t mk_a(bit is_l, bit we, logic [7:0] rd);
        ack_exp_t e;
        e.is_l = is_l; e.we = we; e.rdata = rd;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name, input int act, input int exp);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (mem_en) begin
            n_mem_en++;
            mem_en_cyc = cyc;
            if (mq.size() == 0) begin
                note_fail("mem_en_unexpected", 1, 0);
            end else begin
                mon_me = mq.pop_front();
                chk("mem_addr", mem_addr, mon_me.addr);
                chk("mem_we", mem_we, mon_me.we);
                chk("mem_grant", grant, mon_me.is_l ? 2 : 1);
                if (mon_me.we) chk("mem_wdata", mem_wdata, mon_me.wdata);
            end
        end
        if (c_ack && l_ack) begin
            note_fail("ack_both_high", 1, 0);
        end else if (c_ack || l_ack) begin
            if (aq.size() == 0) begin
                note_fail("ack_unexpected", 1, 0);
            end else begin
                mon_ae = aq.pop_front();
                chk("ack_owner_l", l_ack, mon_ae.is_l);
                chk("ack_grant", grant, mon_ae.is_l ? 2 : 1);
                if (!mon_ae.we) chk("ack_rdata", rdata, mon_ae.rdata);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit is_l, input bit req, input bit we,
                         input logic [7:0] addr, input logic [7:0] wdata);
        if (is_l) begin
            l_req = req; l_we = we; l_addr = addr; l_wdata = wdata;
        end else begin
            c_req = req; c_we = we; c_addr = addr; c_wdata = wdata;
        end
    endtask

    task automatic wait_ack(input bit is_l, output int at);
        bit found;
        found = 1'b0;
        at = -1;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (is_l ? l_ack : c_ack) begin
                found = 1'b1;
                at = cyc;
            end
        end
        if (!found) note_fail(is_l ? "ack_timeout_l" : "ack_timeout_c", 0, 1);
    endtask

    task automatic xfer(input bit is_l, input bit we, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] rexp);
        int t;
        int at;
        @(posedge clk); #1;
        t = cyc;
        mq.push_back(mk_m(is_l, we, addr, wdata));
        aq.push_back(mk_a(is_l, we, rexp));
        drive(is_l, 1'b1, we, addr, wdata);
        wait_ack(is_l, at);
        if (at >= 0) begin
            chk("xfer_ack_latency", at - t, we ? 2 : 3);
            chk("xfer_mem_en_latency", mem_en_cyc - t, 1);
        end
        @(posedge clk); #1;
        drive(is_l, 1'b0, we, addr, wdata);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_grant", grant, 0);
    endtask

    task automatic port_seq(input bit is_l, input int n,
                            input bit we0, input logic [7:0] a0, input logic [7:0] d0,
                            input bit we1, input logic [7:0] a1, input logic [7:0] d1);
        int at;
        drive(is_l, 1'b1, we0, a0, d0);
        wait_ack(is_l, at);
        if (n > 1) begin
            @(posedge clk); #1;
            drive(is_l, 1'b1, we1, a1, d1);
            wait_ack(is_l, at);
        end
        @(posedge clk); #1;
        drive(is_l, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t;
        int at;
        int at_c;
        int n0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_c_ack", c_ack, 0);
        chk("rst_l_ack", l_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single writes and a single read
        xfer(1'b0, 1'b1, 8'h10, 8'hA5, 8'h00);
        xfer(1'b1, 1'b1, 8'h10, 8'h3C, 8'h00);
        xfer(1'b1, 1'b0, 8'h10, 8'h00, 8'h3C);
        chk("read_keeps_wdata", mem_wdata, 8'h3C);

        // Held tie: C, L, C, L
        @(posedge clk); #1;
        mq.push_back(mk_m(1'b0, 1'b1, 8'h20, 8'h01));
        mq.push_back(mk_m(1'b1, 1'b1, 8'h30, 8'h02));
        mq.push_back(mk_m(1'b0, 1'b0, 8'h20, 8'h00));
        mq.push_back(mk_m(1'b1, 1'b0, 8'h30, 8'h00));
        aq.push_back(mk_a(1'b0, 1'b1, 8'h00));
        aq.push_back(mk_a(1'b1, 1'b1, 8'h00));
        aq.push_back(mk_a(1'b0, 1'b0, 8'h01));
        aq.push_back(mk_a(1'b1, 1'b0, 8'h02));
        n0 = n_mem_en;
        fork
            port_seq(1'b0, 2, 1'b1, 8'h20, 8'h01, 1'b0, 8'h20, 8'h00);
            port_seq(1'b1, 2, 1'b1, 8'h30, 8'h02, 1'b0, 8'h30, 8'h00);
        join
        @(negedge clk);
        chk("tie_mem_en_count", n_mem_en - n0, 4);

        // MEM_LAT = 3 read on the second instance
        @(posedge clk); #1;
        t = cyc;
        c2_req = 1'b1; c2_addr = 8'h55;
        at = -1;
        for (int k = 0; k < 20 && at < 0; k++) begin
            @(negedge clk);
            if (c2_ack) at = cyc;
        end
        if (at < 0) begin
            note_fail("lat3_ack_timeout", 0, 1);
        end else begin
            chk("lat3_mem_en", mem_en2_cyc - t, 1);
            chk("lat3_ack", at - t, 5);
            chk("lat3_rdata", rdata2, 8'h99);
            chk("lat3_mem_addr", mem_addr2, 8'h55);
        end
        @(posedge clk); #1;
        c2_req = 1'b0;

        // Mid-flight: C addr change ignored, L served right after C
        @(posedge clk); #1;
        mq.push_back(mk_m(1'b0, 1'b0, 8'h20, 8'h00));
        mq.push_back(mk_m(1'b1, 1'b0, 8'h10, 8'h00));
        aq.push_back(mk_a(1'b0, 1'b0, 8'h01));
        aq.push_back(mk_a(1'b1, 1'b0, 8'h3C));
        drive(1'b0, 1'b1, 1'b0, 8'h20, 8'h00);
        @(posedge clk); #1;
        c_addr = 8'h30;
        drive(1'b1, 1'b1, 1'b0, 8'h10, 8'h00);
        wait_ack(1'b0, at_c);
        @(posedge clk); #1;
        c_req = 1'b0;
        wait_ack(1'b1, at);
        if (at_c >= 0 && at >= 0) begin
            chk("mid_l_mem_en", mem_en_cyc - at_c, 2);
            chk("mid_l_ack", at - at_c, 4);
        end
        @(posedge clk); #1;
        l_req = 1'b0;

        // Reset during S_WAIT aborts the read
        @(posedge clk); #1;
        mq.push_back(mk_m(1'b0, 1'b0, 8'h20, 8'h00));
        drive(1'b0, 1'b1, 1'b0, 8'h20, 8'h00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        c_req = 1'b0;
        @(negedge clk);
        chk("abort_c_ack", c_ack, 0);
        chk("abort_busy", busy, 0);
        chk("abort_grant", grant, 0);
        chk("abort_mem_en", mem_en, 0);
        chk("abort_rdata", rdata, 0);

        // Tie after reset grants C first
        @(posedge clk); #1;
        mq.push_back(mk_m(1'b0, 1'b1, 8'h40, 8'h55));
        mq.push_back(mk_m(1'b1, 1'b1, 8'h41, 8'h66));
        aq.push_back(mk_a(1'b0, 1'b1, 8'h00));
        aq.push_back(mk_a(1'b1, 1'b1, 8'h00));
        fork
            port_seq(1'b0, 1, 1'b1, 8'h40, 8'h55, 1'b0, 8'h00, 8'h00);
            port_seq(1'b1, 1, 1'b1, 8'h41, 8'h66, 1'b0, 8'h00, 8'h00);
        join

        repeat (4) @(negedge clk);
        chk("mem_queue_drained", mq.size(), 0);
        chk("ack_queue_drained", aq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
